imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 205 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time loader. It receives a program image as a byte stream and writes it
// into instruction memory one 32-bit word at a time. The processor core is held
// in reset until the whole image has been written.
//
// Stream layout: word count N (16-bit, little-endian), then 4*N payload bytes.
// Each word is little-endian, so its first byte lands in bits 7:0.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When this macro is defined, one checksum byte follows the payload. The byte
//   must equal the XOR of all payload bytes. If it matches, the load completes.
//   If it does not, the loader stops in the error state.
//
// Parameters
//   MAX_WORDS  largest image size accepted, in words (1..65535)
//   BASE_ADDR  byte address of the first word written
//
// Ports
//   CLK         clock; all state changes happen on its rising edge
//   RST         synchronous, active-high reset
//   rx_valid    a byte is present on rx_data
//   rx_data     image byte
//   rx_ready    loader can accept a byte this cycle
//   imem_we     one-cycle write strobe to instruction memory
//   imem_addr   word-aligned byte address of the write
//   imem_wdata  word to write
//   core_rst    holds the core in reset until the load has completed
//   done        image loaded; stays set until RST
//   error       image rejected; stays set until RST
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  // State entered after the last payload word, or directly when the header
  // gives N = 0.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e PAYLOAD_END = S_CHK;
`else
  localparam state_e PAYLOAD_END = S_DONE;
`endif

  state_e        state_q, state_d;
  logic [15:0]   n_q, n_d;             // word count from the header
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [23:0]   shift_q, shift_d;     // first three bytes of the current word
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          accept;
  logic [15:0]   n_hdr;

  // The header states, the payload state and the checksum state all take bytes.
  // The two terminal states take none.
  assign rx_ready   = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept     = rx_valid && rx_ready;
  assign n_hdr      = {rx_data, n_q[7:0]};

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);

  // NOTE: every signal written below gets a default value first. This way no
  // path through the case statement can leave a signal unassigned and infer a
  // latch.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      S_HDR_LO: begin
        if (accept) begin
          n_d[7:0] = rx_data;
          state_d  = S_HDR_HI;
        end
      end

      S_HDR_HI: begin
        if (accept) begin
          n_d = n_hdr;
          if (n_hdr == 16'd0) begin
            state_d = PAYLOAD_END;
          end else if (32'(n_hdr) > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // The word is complete, so register the write for the next
            // cycle. A byte arriving in that cycle starts the next word;
            // the old contents of shift_q are simply overwritten.
            we_d       = 1'b1;
            wdata_d    = {rx_data, shift_q};
            addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
            if ((word_idx_q + 16'd1) == n_q) begin
              state_d = PAYLOAD_END;
            end
          end else begin
            shift_d = {rx_data, shift_q[23:8]};
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      S_DONE, S_ERR: begin
        // Terminal states; only RST leaves them.
      end

      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the clock edge, whatever order the statements are in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_HDR_LO;
      n_q        <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_idx_q <= 16'd0;
      shift_q    <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed testbench for imem_loader.
//   - The stimulus tasks push each expected memory write into a queue.
//   - A monitor on the falling clock edge pops an entry whenever imem_we is
//     high and compares address and data.
//   - A write that arrives with nothing queued is an error.
// The checksum cases are built only when IMEM_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int unsigned MAX_WORDS = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  imem_loader #(
    .MAX_WORDS (MAX_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_idx = 0;
  logic [7:0] model_csum = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each write strobe consumes one expected write.
  always @(negedge CLK) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  // Drive one byte for one cycle. With gap set, rx_valid is then held low for
  // one cycle.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (gap) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Send one word, least significant byte first, and queue its expected write.
  // The strobe must be low after each of the first three bytes. It must be
  // high in the cycle right after the fourth byte.
  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [7:0] b;
    wr_t        e;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      model_csum = model_csum ^ b;
      if (i == 3) begin
        e.addr = BASE_ADDR + 32'(exp_idx) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        exp_idx++;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      check("we_timing", 32'(imem_we), (i == 3) ? 32'd1 : 32'd0);
      if (gap) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  // Send the trailing checksum byte if the feature is built in. With bad set,
  // the byte is corrupted.
  task automatic finish_image(input bit bad, input bit gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(model_csum ^ (bad ? 8'h01 : 8'h00), gap);
`else
    if (bad || gap) begin
      // Without the checksum feature nothing follows the payload.
    end
`endif
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST        = 1'b0;
    exp_idx    = 0;
    model_csum = 8'h00;
  endtask

  task automatic drain_check(input string name);
    repeat (3) @(posedge CLK);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_loaded(input string tag);
    check({tag, "_done"},     32'(done),     32'd1);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    check({tag, "_error"},    32'(error),    32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic send_ref_image(input bit gap);
    send_byte(8'h02, gap);
    send_byte(8'h00, gap);
    send_word(32'h00A0_0513, gap);
    send_word(32'h0010_0593, gap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  k8;
    logic [31:0] w;

    // Reset state.
    do_reset();
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_we",       32'(imem_we),  32'd0);
    check("rst_addr",     imem_addr,     BASE_ADDR);
    check("rst_wdata",    imem_wdata,    32'd0);

    // Reference image, one byte per cycle.
    send_ref_image(1'b0);
    finish_image(1'b0, 1'b0);
    check_loaded("ref");
    drain_check("ref_drain");
    // Address and data hold their last values once writes stop.
    check("hold_addr",  imem_addr,  32'h0000_0004);
    check("hold_wdata", imem_wdata, 32'h0010_0593);
    // The done state is terminal: offered bytes are ignored.
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (8) @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    check("term_done",     32'(done),     32'd1);
    check("term_rx_ready", 32'(rx_ready), 32'd0);
    drain_check("term_drain");

    // Same image with rx_valid toggling every cycle.
    do_reset();
    send_ref_image(1'b1);
    finish_image(1'b0, 1'b1);
    check_loaded("toggle");
    drain_check("toggle_drain");

    // Oversized header: N = 257.
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("big_error",    32'(error),    32'd1);
    check("big_rx_ready", 32'(rx_ready), 32'd0);
    check("big_core_rst", 32'(core_rst), 32'd1);
    check("big_done",     32'(done),     32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (6) @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    check("big_error_sticky", 32'(error), 32'd1);
    drain_check("big_drain");

    // Reset after three payload bytes. A fourth byte is offered in the reset
    // cycle and must be dropped.
    do_reset();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hA0, 1'b0);
    RST      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    rx_valid = 1'b0;
    exp_idx    = 0;
    model_csum = 8'h00;
    check("abort_we",       32'(imem_we),  32'd0);
    check("abort_rx_ready", 32'(rx_ready), 32'd1);
    check("abort_addr",     imem_addr,     BASE_ADDR);
    send_ref_image(1'b0);
    finish_image(1'b0, 1'b0);
    check_loaded("abort");
    drain_check("abort_drain");

    // Empty image: N = 0.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    // done must already be high two cycles after the first header byte.
    check("empty_done_2cyc", 32'(done), 32'd1);
`endif
    finish_image(1'b0, 1'b0);
    check_loaded("empty");
    drain_check("empty_drain");

    // Largest accepted image: N = MAX_WORDS = 256. The last write goes to
    // address 0x3FC.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      w  = {k8 ^ 8'h5A, k8, 8'hC3, ~k8};
      send_word(w, 1'b0);
    end
    finish_image(1'b0, 1'b0);
    check_loaded("max");
    drain_check("max_drain");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum that does not match the payload.
    do_reset();
    send_ref_image(1'b0);
    finish_image(1'b1, 1'b0);
    check("bad_csum_error",    32'(error),    32'd1);
    check("bad_csum_core_rst", 32'(core_rst), 32'd1);
    check("bad_csum_done",     32'(done),     32'd0);
    drain_check("bad_csum_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
